// File: rtl/led_breath_pkg.sv
// Shared types and defaults for the led_breath LED driver.
// Optional gamma path is enabled by defining LED_GAMMA_EN (see led_pwm).
package led_breath_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RISE    = 3'd1,
    HOLD_HI = 3'd2,
    FALL    = 3'd3,
    HOLD_LO = 3'd4
  } state_t;

  localparam int DEF_PWM_BITS     = 8;
  localparam int DEF_STEP_PERIODS = 48;
  localparam int DEF_HOLD_STEPS   = 64;

  // Width needed for a counter over 0..n-1, never less than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_breath_pwm.sv
// PWM counter and registered comparator for led_breath.
// With LED_GAMMA_EN defined the duty is squared before comparison.
module led_pwm
  import led_breath_pkg::*;
#(
  parameter int PWM_BITS = DEF_PWM_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic [PWM_BITS-1:0] duty,
  output logic                led,
  output logic                period_end
);

  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty_eff;

`ifdef LED_GAMMA_EN
  // Combinational square keeps the counter-to-pin latency at one cycle.
  logic [2*PWM_BITS-1:0] duty_sq;
  assign duty_sq  = {{PWM_BITS{1'b0}}, duty} * {{PWM_BITS{1'b0}}, duty};
  assign duty_eff = PWM_BITS'(duty_sq >> PWM_BITS);
`else
  assign duty_eff = duty;
`endif

  assign period_end = (pwm_cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led <= 1'b0;
    end else begin
      led <= (pwm_cnt < duty_eff);
    end
  end

endmodule

// File: rtl/led_breath.sv
// Breathing LED driver: ramps PWM brightness up, holds, ramps down, holds.
// Define LED_GAMMA_EN for a squared (perceptual) brightness curve.
module led_breath
  import led_breath_pkg::*;
#(
  parameter int PWM_BITS     = DEF_PWM_BITS,
  parameter int STEP_PERIODS = DEF_STEP_PERIODS,
  parameter int HOLD_STEPS   = DEF_HOLD_STEPS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       led,
  output logic       busy,
  output logic [2:0] phase
);

  localparam int SW = clog2_min1(STEP_PERIODS);
  localparam int HW = clog2_min1(HOLD_STEPS);
  localparam logic [SW-1:0]       STEP_LAST = SW'(STEP_PERIODS - 1);
  localparam logic [HW-1:0]       HOLD_LAST = HW'(HOLD_STEPS - 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;

  state_t              state, state_next;
  logic [PWM_BITS-1:0] duty, duty_next, duty_inc, duty_dec;
  logic [SW-1:0]       step_cnt, step_next;
  logic [HW-1:0]       hold_cnt, hold_next;
  logic                busy_next;
  logic                period_end;
  logic                tick;
  logic                pwm_clear;

  assign tick      = period_end && (step_cnt == STEP_LAST);
  assign duty_inc  = duty + PWM_BITS'(1);
  assign duty_dec  = duty - PWM_BITS'(1);
  assign pwm_clear = (state == IDLE) || !en;
  assign phase     = state;

  led_pwm #(
    .PWM_BITS(PWM_BITS)
  ) u_pwm (
    .clk        (clk),
    .rst        (rst),
    .clear      (pwm_clear),
    .duty       (duty),
    .led        (led),
    .period_end (period_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      duty     <= '0;
      step_cnt <= '0;
      hold_cnt <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_next;
      duty     <= duty_next;
      step_cnt <= step_next;
      hold_cnt <= hold_next;
      busy     <= busy_next;
    end
  end

  always_comb begin
    state_next = state;
    duty_next  = duty;
    step_next  = step_cnt;
    hold_next  = hold_cnt;

    if (state == IDLE || !en) begin
      // Dropping en is an immediate stop: no fade-out, nothing resumed later.
      duty_next  = '0;
      step_next  = '0;
      hold_next  = '0;
      state_next = (state == IDLE && en) ? RISE : IDLE;
    end else begin
      if (period_end) begin
        step_next = (step_cnt == STEP_LAST) ? '0 : step_cnt + SW'(1);
      end
      if (tick) begin
        unique case (state)
          RISE: begin
            duty_next = duty_inc;
            if (duty_inc == DUTY_MAX) begin
              state_next = HOLD_HI;
              hold_next  = '0;
            end
          end
          FALL: begin
            duty_next = duty_dec;
            if (duty_dec == '0) begin
              state_next = HOLD_LO;
              hold_next  = '0;
            end
          end
          HOLD_HI, HOLD_LO: begin
            if (hold_cnt == HOLD_LAST) begin
              hold_next  = '0;
              state_next = (state == HOLD_HI) ? FALL : RISE;
            end else begin
              hold_next = hold_cnt + HW'(1);
            end
          end
          default: state_next = IDLE;
        endcase
      end
    end

    busy_next = (state_next != IDLE);
  end

endmodule

// File: tb/tb_led_breath.sv
// Directed self-checking bench for led_breath (PWM_BITS=3, STEP_PERIODS=2, HOLD_STEPS=2).
// Expected brightness levels switch to the squared curve when LED_GAMMA_EN is defined.
module tb_led_breath;

  logic       clk;
  logic       rst;
  logic       en;
  logic       led;
  logic       busy;
  logic [2:0] phase;

  int checks;
  int errors;
  int edge_n;
  int highs;

`ifdef LED_GAMMA_EN
  localparam int DEFF_3   = 1;
  localparam int DEFF_1   = 0;
  localparam int HIGHS_HI = 6;
`else
  localparam int DEFF_3   = 3;
  localparam int DEFF_1   = 1;
  localparam int HIGHS_HI = 7;
`endif

  led_breath #(
    .PWM_BITS     (3),
    .STEP_PERIODS (2),
    .HOLD_STEPS   (2)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .led   (led),
    .busy  (busy),
    .phase (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step_clk();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic advance_to(input int target);
    while (edge_n < target) step_clk();
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Counts led-high samples over the next n edges.
  task automatic count_highs(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      step_clk();
      if (led === 1'b1) cnt++;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    edge_n = 0;
    rst    = 1'b1;
    en     = 1'b1;

    repeat (3) step_clk();
    check_output("reset_led", {31'b0, led}, 0);
    check_output("reset_busy", {31'b0, busy}, 0);
    check_output("reset_phase", {29'b0, phase}, 0);

    // Edge 0 is the first edge with rst low; counting restarts there.
    rst    = 1'b0;
    edge_n = -1;
    step_clk();
    check_output("start_phase", {29'b0, phase}, 1);
    check_output("start_busy", {31'b0, busy}, 1);

    // duty becomes 3 at edge 48; led follows pwm_cnt with one cycle of lag.
    advance_to(48);
    for (int i = 0; i < 8; i++) begin
      step_clk();
      check_output("duty3_led", {31'b0, led}, (((edge_n - 1) % 8) < DEFF_3) ? 1 : 0);
    end

    advance_to(111);
    check_output("rise_end_phase", {29'b0, phase}, 1);
    step_clk();
    check_output("hold_hi_phase", {29'b0, phase}, 2);

    count_highs(8, highs);
    check_output("hold_hi_highs", highs, HIGHS_HI);

    advance_to(143);
    check_output("hold_hi_end_phase", {29'b0, phase}, 2);
    step_clk();
    check_output("fall_phase", {29'b0, phase}, 3);

    advance_to(255);
    check_output("fall_end_phase", {29'b0, phase}, 3);
    step_clk();
    check_output("hold_lo_phase", {29'b0, phase}, 4);

    count_highs(31, highs);
    check_output("hold_lo_highs", highs, 0);
    check_output("hold_lo_end_phase", {29'b0, phase}, 4);
    step_clk();
    check_output("rerise_phase", {29'b0, phase}, 1);

    // Second loop: FALL spans edges 432..544; drop en mid-ramp at duty=6.
    advance_to(460);
    check_output("pre_disable_phase", {29'b0, phase}, 3);
    en = 1'b0;
    step_clk();
    check_output("disable_phase", {29'b0, phase}, 0);
    check_output("disable_busy", {31'b0, busy}, 0);
    count_highs(8, highs);
    check_output("disable_led_highs", highs, 0);
    check_output("disabled_phase", {29'b0, phase}, 0);

    en     = 1'b1;
    edge_n = -1;
    step_clk();
    check_output("reenable_phase", {29'b0, phase}, 1);
    check_output("reenable_busy", {31'b0, busy}, 1);
    count_highs(16, highs);
    check_output("restart_duty0_highs", highs, 0);
    count_highs(8, highs);
    check_output("restart_duty1_highs", highs, DEFF_1);

    advance_to(111);
    check_output("restart_rise_phase", {29'b0, phase}, 1);
    step_clk();
    check_output("restart_hold_hi_phase", {29'b0, phase}, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_breath.md
Name: led_breath

Overview:
- Sequential LED driver that feeds the board LED pin, which the existing always-on LED design ties high.
- Produces a "breathing" pattern: PWM brightness ramps up, holds at full, ramps down, then holds at dark, repeating while enabled.
- Sits between the board clock and the top-level led output on the ColorLight 5A-75B.

Parameters:
- PWM_BITS, 8: width of the PWM counter and duty register; the PWM period is 2^PWM_BITS clocks.
- STEP_PERIODS, 48: PWM periods per brightness step (one tick).
- HOLD_STEPS, 64: ticks spent in each hold state; must be >= 1.

Ports:
- clk  in  1  board clock (25 MHz).
- rst  in  1  synchronous, active-high reset.
- en  in  1  pattern enable; level-sensitive.
- led  out  1  PWM LED drive, active-high, registered.
- busy  out  1  high whenever the FSM is not in IDLE.
- phase  out  3  current state encoding: IDLE=0, RISE=1, HOLD_HI=2, FALL=3, HOLD_LO=4.

Behaviour:
- Reset (rst=1 at a clk edge) clears all of the following: led=0, busy=0, phase=IDLE, duty=0, pwm_cnt=0, step_cnt=0, hold_cnt=0. rst has priority over en.
- pwm_cnt increments every clock while not IDLE, wrapping from 2^PWM_BITS-1 to 0. It is held at 0 in IDLE.
- led is registered as (pwm_cnt < duty_eff), giving 1-cycle latency from counter to pin.
  - duty_eff = 0 means led is constantly 0.
  - duty_eff = MAX = 2^PWM_BITS-1 means led is low for 1 cycle per period.
- step_cnt advances when pwm_cnt == MAX and wraps at STEP_PERIODS-1.
- tick is asserted for a single cycle when pwm_cnt == MAX and step_cnt == STEP_PERIODS-1.
- FSM transitions, all evaluated on the clk edge:
  - IDLE: if en=1, go to RISE next cycle; pwm_cnt, step_cnt and duty start at 0.
  - RISE: on each tick, duty += 1. On the tick where duty becomes MAX, go to HOLD_HI with hold_cnt=0.
  - HOLD_HI: on each tick, hold_cnt += 1. On the tick with hold_cnt == HOLD_STEPS-1, go to FALL.
  - FALL: on each tick, duty -= 1. On the tick where duty becomes 0, go to HOLD_LO with hold_cnt=0.
  - HOLD_LO: same hold rule as HOLD_HI, then go to RISE.
- en=0 in any non-IDLE state:
  - Next cycle: phase=IDLE, duty=0, all counters cleared.
  - led is 0 from the following cycle.
  - No fade-out.
- en re-asserted: the pattern restarts from RISE with duty=0. No state is resumed.
- Boundaries:
  - duty never wraps; increments saturate at MAX and decrements stop at 0 by construction.
  - Arithmetic is unsigned, PWM_BITS wide.
  - step_cnt and hold_cnt are clog2-sized with a minimum width of 1.
- busy equals (phase != IDLE), registered together with phase.

Optional Feature:
- LED_GAMMA_EN
  - When defined: duty_eff = (duty*duty) >> PWM_BITS, computed in 2*PWM_BITS width and truncated to PWM_BITS, giving a perceptual fade. The FSM is unchanged; the led output keeps its 1-cycle latency, with the square computed combinationally or pipelined so that latency is preserved.
  - When not defined: duty_eff = duty, linear.

Decomposition:
- Package led_breath_pkg holds:
  - state enum (IDLE..HOLD_LO with the 3-bit encodings above);
  - default parameter constants;
  - function clog2_min1.
- One natural sub-module, led_pwm:
  - contents: pwm_cnt plus the registered comparator (and the gamma path when LED_GAMMA_EN is defined);
  - outputs: led and period_end.
- led_breath owns step_cnt, hold_cnt, duty and the FSM.

Test Plan (all scenarios use PWM_BITS=3, STEP_PERIODS=2, HOLD_STEPS=2, giving tick every 16 clocks):
- Reset with en=1 held high: during rst, led=0, busy=0, phase=0. First cycle after rst release: phase=1.
- Full-cycle timing: en=1 constant.
  - RISE lasts 7 ticks (112 clocks) before phase=2.
  - HOLD_HI lasts 32 clocks, then phase=3.
  - FALL lasts 112 clocks, then phase=4.
  - HOLD_LO lasts 32 clocks, then phase=1.
- PWM duty check at duty=3 (linear build): led high for exactly 3 of every 8 clocks, offset one cycle after pwm_cnt 0..2.
- Hold-level checks:
  - HOLD_HI: led high 7 of 8 clocks.
  - HOLD_LO: led 0 every cycle.
- Mid-operation disable: drop en during FALL.
  - Next cycle: phase=0, busy=0.
  - led=0 from the cycle after.
  - Re-raise en: phase=1 and duty restarts at 0.
- Gamma build (LED_GAMMA_EN) in HOLD_HI: duty=7 gives duty_eff=(49>>3)=6, so led is high 6 of 8 clocks.
